pattern_busy_ctrl: RTL
======================

# pattern_busy_ctrl

Registers the best-of-5 half-strip pattern result and qualifies it as a CLCT candidate. Maintains a per-CFEB dead-time timer that drives the five busy flags fed back into best-of-5 selection. Also counts cycles in which every CFEB was busy. Sits directly downstream of the best 1-of-5 sorter and closes the busy loop around it.

## Interface
Parameters:
- MXPATB, 7, pattern bits: [6:4] hit count, [3:0] bend/id
- MXKEYBX, 8, key bits: [7:5] CFEB index, [4:0] half-strip within CFEB
- MXCFEB, 5, number of CFEBs
- EDGE, 2, half-strips from a CFEB boundary that also mark the neighbour busy
- MXBSYB, 4, busy-timer width
- MXCNTB, 16, all-busy counter width

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- best_pat  in  MXPATB  selected pattern
- best_key  in  MXKEYBX  selected key
- best_bsy  in  1  all CFEBs busy, no selection
- hit_thresh  in  3  minimum hit count for a valid CLCT (0 treated as 1)
- busy_len  in  MXBSYB  dead time in clocks (0 = busy disabled)
- cnt_clear  in  1  synchronous clear of all-busy counter
- clct_vld  out  1  registered valid CLCT
- clct_pat  out  MXPATB  registered pattern
- clct_key  out  MXKEYBX  registered key
- cfeb_bsy  out  MXCFEB  busy flags to sorter: bit i is bsy<i>
- allbsy_cnt  out  MXCNTB  saturating count of best_bsy cycles

## Operation
- Qualify: cand = !best_bsy && best_pat[6:4] >= max(hit_thresh,1) && best_key[7:5] < MXCFEB.
- Register: every clock, clct_pat/clct_key <= cand ? best_pat/best_key : 0, and clct_vld <= cand.
- Busy marking on cand, with c = best_key[7:5] and h = best_key[4:0]:
  - CFEB c is always marked.
  - CFEB c-1 is also marked if h < EDGE and c > 0.
  - CFEB c+1 is also marked if h > 31-EDGE and c < MXCFEB-1.
- Per-CFEB timer: a marked timer loads busy_len. Load has priority over decrement. An unmarked nonzero timer decrements by 1. Zero holds.
- Marking an already-busy CFEB reloads it with busy_len (restarts dead time).
- cfeb_bsy[i] = (timer[i] != 0), driven directly from registers with no combinational path from inputs.
- All-busy counter:
  - Increments each clock best_bsy=1 and saturates at 2^MXCNTB-1.
  - cnt_clear has priority over increment.
- busy_len changes apply only at the next load. Running timers are unaffected.

## Timing
- Reset values: clct_vld=0, clct_pat=0, clct_key=0, all timers 0 (cfeb_bsy=0), allbsy_cnt=0.
- Latency: best_* to clct_* is 1 clock.
- cand at edge N gives cfeb_bsy set for clocks N+1 through N+busy_len, then clears at N+busy_len+1. The sorter sees the mask one clock after selection.
- busy_len=1: the CFEB is busy for exactly one cycle.
- Reset asserted mid-dead-time clears all timers and the counter immediately. No pending state survives.
- Simultaneous load on a CFEB whose timer reads 1: load wins and the timer becomes busy_len.
- Loop path: cfeb_bsy reg → sorter (combinational) → this block's registers. Must close in one clock.

## Structure
- Shared package/include holds: MXPATB, MXKEYBX, MXCFEB, the hit-field slice [6:4], and the CFEB-index slice [7:5].
- One sub-module, cfeb_busy_timer, instantiated MXCFEB times. Ports: clock, reset, load, len, busy. Contains the load/decrement/hold logic.
- Top level contains qualification, edge-neighbour decode, output registers, and the all-busy counter.

## Test plan
- Reset check:
  - Stimulus: assert reset with random inputs.
  - Response: all outputs 0. After release with best_bsy=0 and best_pat=0, clct_vld stays 0.
- Basic capture and dead time:
  - Stimulus: hit_thresh=3, busy_len=4, best_pat=7'h62, best_key=8'h4A (CFEB2, hs 10), one clock.
  - Response: next clock clct_vld=1, clct_key=8'h4A, and cfeb_bsy=5'b00100 for exactly 4 clocks.
- Edge spread:
  - Stimulus: EDGE=2, busy_len=3, best_key=8'h21 (CFEB1, hs 1).
  - Response: cfeb_bsy=5'b00011 for 3 clocks.
  - Stimulus: best_key=8'h9F (CFEB4, hs 31).
  - Response: only bit 4 set (no CFEB5).
- Reload and threshold:
  - Stimulus: re-mark CFEB0 when its timer=1, busy_len=5.
  - Response: busy for 5 more clocks.
  - Stimulus: pattern with 2 hits, hit_thresh=3.
  - Response: clct_vld=0 and no busy.
- All-busy counter:
  - Stimulus: best_bsy=1 for 10 clocks.
  - Response: allbsy_cnt=10.
  - Stimulus: cnt_clear together with best_bsy=1.
  - Response: counter reads 0 next clock.
  - Stimulus: force near saturation.
  - Response: holds at 16'hFFFF.
- Mid-operation reset:
  - Stimulus: assert reset during a busy_len=15 dead time.
  - Response: cfeb_bsy=0 asynchronously. After release, a fresh cand marks normally.

Source files
------------

// File: rtl/pattern_busy_ctrl_pkg.sv
// Shared widths and field slices for the best-of-5 pattern result and the
// busy loop that feeds back into the sorter.
package pattern_busy_ctrl_pkg;

  localparam int MXPATB  = 7;
  localparam int MXKEYBX = 8;
  localparam int MXCFEB  = 5;

  localparam int HIT_HI  = 6;
  localparam int HIT_LO  = 4;
  localparam int CFEB_HI = 7;
  localparam int CFEB_LO = 5;
  localparam int HS_MAX  = (1 << CFEB_LO) - 1;

  function automatic logic [HIT_HI-HIT_LO:0] pat_hits(input logic [MXPATB-1:0] pat);
    return pat[HIT_HI:HIT_LO];
  endfunction

  function automatic logic [CFEB_HI-CFEB_LO:0] key_cfeb(input logic [MXKEYBX-1:0] key);
    return key[CFEB_HI:CFEB_LO];
  endfunction

  function automatic logic [CFEB_LO-1:0] key_hs(input logic [MXKEYBX-1:0] key);
    return key[CFEB_LO-1:0];
  endfunction

endpackage

// File: rtl/pattern_busy_ctrl_cfeb_busy_timer.sv
// Dead-time timer for one CFEB: load restarts the count, otherwise it runs
// down to zero and holds. Busy is taken straight from the count register.
module cfeb_busy_timer #(
  parameter int MXBSYB = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [MXBSYB-1:0] len,
  output logic              busy
);

  logic [MXBSYB-1:0] r_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= len;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign busy = (r_cnt != '0);

endmodule

// File: rtl/pattern_busy_ctrl.sv
// Registers and qualifies the best-of-5 pattern as a CLCT candidate, drives
// per-CFEB dead-time busy flags back to the sorter, and counts all-busy cycles.
module pattern_busy_ctrl
  import pattern_busy_ctrl_pkg::*;
#(
  parameter int EDGE   = 2,
  parameter int MXBSYB = 4,
  parameter int MXCNTB = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [MXPATB-1:0]  best_pat,
  input  logic [MXKEYBX-1:0] best_key,
  input  logic               best_bsy,
  input  logic [2:0]         hit_thresh,
  input  logic [MXBSYB-1:0]  busy_len,
  input  logic               cnt_clear,
  output logic               clct_vld,
  output logic [MXPATB-1:0]  clct_pat,
  output logic [MXKEYBX-1:0] clct_key,
  output logic [MXCFEB-1:0]  cfeb_bsy,
  output logic [MXCNTB-1:0]  allbsy_cnt
);

  logic [2:0]               w_hits;
  logic [2:0]               w_thresh;
  logic [CFEB_HI-CFEB_LO:0] w_cfeb;
  logic [CFEB_LO-1:0]       w_hs;
  logic                     w_cand;
  logic [MXCFEB-1:0]        w_mark;
  logic [MXCFEB-1:0]        w_busy;

  logic                     r_vld;
  logic [MXPATB-1:0]        r_pat;
  logic [MXKEYBX-1:0]       r_key;
  logic [MXCNTB-1:0]        r_cnt;

  assign w_hits   = pat_hits(best_pat);
  assign w_cfeb   = key_cfeb(best_key);
  assign w_hs     = key_hs(best_key);
  assign w_thresh = (hit_thresh == 3'd0) ? 3'd1 : hit_thresh;
  assign w_cand   = !best_bsy && (w_hits >= w_thresh) && (int'(w_cfeb) < MXCFEB);

  // A key near a CFEB boundary also blocks the neighbour on that side.
  always_comb begin
    w_mark = '0;
    for (int i = 0; i < MXCFEB; i++) begin
      if (w_cand && int'(w_cfeb) == i)
        w_mark[i] = 1'b1;
      if (w_cand && int'(w_cfeb) == i + 1 && int'(w_hs) < EDGE)
        w_mark[i] = 1'b1;
      if (w_cand && int'(w_cfeb) + 1 == i && int'(w_hs) > HS_MAX - EDGE)
        w_mark[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < MXCFEB; g++) begin : g_timer
    cfeb_busy_timer #(
      .MXBSYB(MXBSYB)
    ) u_timer (
      .clock(clock),
      .reset(reset),
      .load (w_mark[g]),
      .len  (busy_len),
      .busy (w_busy[g])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vld <= 1'b0;
      r_pat <= '0;
      r_key <= '0;
    end else begin
      r_vld <= w_cand;
      r_pat <= w_cand ? best_pat : '0;
      r_key <= w_cand ? best_key : '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (cnt_clear) begin
      r_cnt <= '0;
    end else if (best_bsy && r_cnt != {MXCNTB{1'b1}}) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign clct_vld   = r_vld;
  assign clct_pat   = r_pat;
  assign clct_key   = r_key;
  assign cfeb_bsy   = w_busy;
  assign allbsy_cnt = r_cnt;

endmodule
